// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 16x oversampled start/data/parity/stop framing into 10-bit FIFO records.
// Optional UART_BREAK_DET_EN: a held break yields one record and a break_o pulse.
`timescale 1ns/1ps
module uart_rx_deser #(
    parameter int OVERSAMPLE = 16,
    parameter int REC_WIDTH  = 10
) (
    input  logic                 clk,
    input  logic                 wb_rst_ni,
    input  logic                 enable,
    input  logic                 srx_pad_i,
    input  logic [7:0]           lcr,
    input  logic                 rx_reset,
    output logic                 rf_push,
    output logic [REC_WIDTH-1:0] rf_data_in,
    output logic                 rx_busy,
    output logic                 break_o
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

`ifdef UART_BREAK_DET_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;
`endif

    typedef struct packed {
        logic       stick;
        logic       eps;
        logic       pen;
        logic [1:0] wls;
    } lcr_t;

    state_t            state_q, state_n;
    logic [1:0]        sync_q;
    logic              rx_s;
    logic [CW-1:0]     cnt_q, cnt_n;
    logic [2:0]        idx_q, idx_n;
    logic [7:0]        data_q, data_n;
    lcr_t              lcr_q, lcr_n;
    logic              par_bit_q, par_bit_n;
    logic              push_n;
    logic              busy_n;
    logic [REC_WIDTH-1:0] rec_n;
    logic              par_exp, par_err, is_break;
    logic              lcr_unused;

    assign rx_s       = sync_q[1];
    assign lcr_unused = ^{lcr[7:6], lcr[2]};

    // Expected parity; unused data MSBs are zero so they do not disturb the XOR.
    assign par_exp  = lcr_q.stick ? ~lcr_q.eps : (^data_q ^ ~lcr_q.eps);
    assign par_err  = lcr_q.pen && (par_bit_q != par_exp);
    assign is_break = (data_q == 8'h00) && (!lcr_q.pen || !par_bit_q) && !rx_s;

`ifdef UART_BREAK_DET_EN
    logic brk_q, brk_n;
    assign break_o = brk_q;
`else
    assign break_o = 1'b0;
`endif

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        idx_n     = idx_q;
        data_n    = data_q;
        lcr_n     = lcr_q;
        par_bit_n = par_bit_q;
        push_n    = 1'b0;
        rec_n     = rf_data_in;
`ifdef UART_BREAK_DET_EN
        brk_n     = 1'b0;
`endif
        case (state_q)
            IDLE: if (enable && !rx_s) begin
                state_n = START;
                cnt_n   = '0;
                lcr_n   = '{stick: lcr[5], eps: lcr[4], pen: lcr[3], wls: lcr[1:0]};
            end
            START: if (enable) begin
                if (cnt_q == HALF_M1) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        idx_n   = '0;
                        data_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            DATA: if (enable) begin
                if (cnt_q == FULL_M1) begin
                    cnt_n         = '0;
                    data_n[idx_q] = rx_s;
                    idx_n         = idx_q + 3'd1;
                    // last index is 4 + wls
                    if (idx_q == {1'b1, lcr_q.wls})
                        state_n = lcr_q.pen ? PARITY : STOP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            PARITY: if (enable) begin
                if (cnt_q == FULL_M1) begin
                    cnt_n     = '0;
                    par_bit_n = rx_s;
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            STOP: if (enable) begin
                if (cnt_q == FULL_M1) begin
                    state_n = PUSH;
                    push_n  = 1'b1;
                    rec_n   = {data_q, par_err, ~rx_s};
`ifdef UART_BREAK_DET_EN
                    if (is_break) begin
                        rec_n = {8'h00, 1'b0, 1'b1};
                        brk_n = 1'b1;
                    end
`endif
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
`ifdef UART_BREAK_DET_EN
            PUSH:      state_n = brk_q ? WAIT_IDLE : IDLE;
            WAIT_IDLE: if (enable && rx_s) state_n = IDLE;
`else
            PUSH:      state_n = IDLE;
`endif
            default:   state_n = IDLE;
        endcase

        if (rx_reset) begin
            state_n = IDLE;
            push_n  = 1'b0;
            rec_n   = rf_data_in;
`ifdef UART_BREAK_DET_EN
            brk_n   = 1'b0;
`endif
        end

        busy_n = (state_n == DATA) || (state_n == PARITY) ||
                 (state_n == STOP) || (state_n == PUSH);
    end

    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync_q     <= 2'b11;
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            lcr_q      <= '0;
            par_bit_q  <= 1'b0;
            rf_push    <= 1'b0;
            rf_data_in <= '0;
            rx_busy    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], srx_pad_i};
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            idx_q      <= idx_n;
            data_q     <= data_n;
            lcr_q      <= lcr_n;
            par_bit_q  <= par_bit_n;
            rf_push    <= push_n;
            rf_data_in <= rec_n;
            rx_busy    <= busy_n;
        end
    end

`ifdef UART_BREAK_DET_EN
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) brk_q <= 1'b0;
        else            brk_q <= brk_n;
    end
`else
    logic is_break_unused;
    assign is_break_unused = is_break;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Randomized bench for uart_rx_deser: serial frames driven bit by bit, records checked against
// a frame-level reference model, plus directed framing/parity/glitch/break/reset cases.
`timescale 1ns/1ps
module tb_uart_rx_deser;

    localparam int TPB      = 4;          // clocks per enable tick
    localparam int BIT_CLKS = 16 * TPB;

    logic       clk = 1'b0;
    logic       wb_rst_ni = 1'b0;
    logic       enable = 1'b0;
    logic       srx_pad_i = 1'b1;
    logic [7:0] lcr = 8'h03;
    logic       rx_reset = 1'b0;
    logic       rf_push;
    logic [9:0] rf_data_in;
    logic       rx_busy;
    logic       break_o;

    int         checks = 0;
    int         errors = 0;
    int         brk_cnt = 0;
    int         exp_brk = 0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    logic       prev_push = 1'b0;

    always #5 clk = ~clk;

    uart_rx_deser dut (
        .clk        (clk),
        .wb_rst_ni  (wb_rst_ni),
        .enable     (enable),
        .srx_pad_i  (srx_pad_i),
        .lcr        (lcr),
        .rx_reset   (rx_reset),
        .rf_push    (rf_push),
        .rf_data_in (rf_data_in),
        .rx_busy    (rx_busy),
        .break_o    (break_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin : tick_gen
        int div = 0;
        forever begin
            @(negedge clk);
            enable = (div == TPB - 1);
            div = (div + 1) % TPB;
        end
    end

    always @(negedge clk) begin
        if (rf_push) begin
            chk("b2b_push", prev_push, 1'b0);
            got_q.push_back(rf_data_in);
        end
        if (break_o) brk_cnt++;
        prev_push = rf_push;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        srx_pad_i = b;
        wait_clks(BIT_CLKS);
    endtask

    // Parity bit a correct transmitter would send for this LCR and payload.
    function automatic logic tx_parity(input logic [7:0] l, input logic [7:0] dm);
        int ones = $countones(dm);
        if (l[5]) return l[4] ? 1'b0 : 1'b1;
        if (l[4]) return (ones % 2 == 1);
        return (ones % 2 == 0);
    endfunction

    task automatic send_frame(input logic [7:0] l, input logic [7:0] d, input bit pflip,
                              input bit stop, input bit scramble);
        int         len = 5 + int'(l[1:0]);
        logic [7:0] dm  = d & 8'((1 << len) - 1);
        logic       pbit = tx_parity(l, dm) ^ pflip;
        logic [9:0] rec = {dm, l[3] && pflip, !stop};
`ifdef UART_BREAK_DET_EN
        if (dm == 8'h00 && !stop && (!l[3] || !pbit)) begin
            rec = 10'h001;
            exp_brk++;
        end
`endif
        exp_q.push_back(rec);
        lcr = l;
        srx_pad_i = 1'b0;
        wait_clks(BIT_CLKS / 2);
        if (scramble) lcr = 8'($urandom);
        wait_clks(BIT_CLKS / 2);
        for (int i = 0; i < len; i++) begin
            if (i == 1) chk("busy_mid", rx_busy, 1'b1);
            send_bit(dm[i]);
        end
        if (l[3]) send_bit(pbit);
        send_bit(stop);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_cnt"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_rec"}, got_q.pop_front(), exp_q.pop_front());
        chk({tag, "_busy"}, rx_busy, 1'b0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_one(input string tag, input logic [9:0] exp);
        chk({tag, "_cnt"}, got_q.size(), 1);
        if (got_q.size() > 0) chk({tag, "_rec"}, got_q[0], exp);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        wait_clks(5);
        chk("rst_push", rf_push, 1'b0);
        chk("rst_data", rf_data_in, 10'h000);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_brk", break_o, 1'b0);
        wb_rst_ni = 1'b1;
        wait_clks(2 * BIT_CLKS);

        // 8N1 0xA5
        send_frame(8'h03, 8'hA5, 1'b0, 1'b1, 1'b0);
        check_one("t1_8n1", {8'hA5, 2'b00});
        // 7E1, wrong parity
        send_frame(8'h1A, 8'h41, 1'b1, 1'b1, 1'b0);
        check_one("t2_7e1", {8'h41, 2'b10});
        // 5N1 framing error, then clean 0x03
        send_frame(8'h00, 8'h1F, 1'b0, 1'b0, 1'b0);
        check_one("t3_frm", {8'h1F, 2'b01});
        send_frame(8'h00, 8'h03, 1'b0, 1'b1, 1'b0);
        check_one("t3_next", {8'h03, 2'b00});

        // start glitch of 4 ticks
        srx_pad_i = 1'b0;
        wait_clks(4 * TPB);
        srx_pad_i = 1'b1;
        wait_clks(2 * BIT_CLKS);
        chk("glitch_cnt", got_q.size(), 0);
        chk("glitch_busy", rx_busy, 1'b0);
        got_q.delete();

        // held break for three 8N1 frame times
        lcr = 8'h03;
        brk_cnt = 0;
        srx_pad_i = 1'b0;
        wait_clks(30 * BIT_CLKS);
`ifdef UART_BREAK_DET_EN
        chk("brk_cnt_rec", got_q.size(), 1);
        chk("brk_pulse", brk_cnt, 1);
`else
        chk("brk_repeat", got_q.size() >= 2, 1'b1);
        chk("brk_none", brk_cnt, 0);
`endif
        while (got_q.size() > 0) chk("brk_rec", got_q.pop_front(), 10'h001);
        srx_pad_i = 1'b1;
        wait_clks(1);
        rx_reset = 1'b1;
        wait_clks(1);
        rx_reset = 1'b0;
        wait_clks(3 * BIT_CLKS);
        chk("rxrst_cnt", got_q.size(), 0);
        chk("rxrst_busy", rx_busy, 1'b0);
        got_q.delete();
        brk_cnt = 0;
        exp_brk = 0;

        // async reset mid-DATA, then clean 0x5A
        lcr = 8'h03;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        wb_rst_ni = 1'b0;
        srx_pad_i = 1'b1;
        #1;
        chk("arst_busy", rx_busy, 1'b0);
        chk("arst_data", rf_data_in, 10'h000);
        chk("arst_push", rf_push, 1'b0);
        wait_clks(4);
        wb_rst_ni = 1'b1;
        wait_clks(2 * BIT_CLKS);
        chk("arst_cnt", got_q.size(), 0);
        got_q.delete();
        send_frame(8'h03, 8'h5A, 1'b0, 1'b1, 1'b0);
        check_one("t6_clean", {8'h5A, 2'b00});

        // random frames against the reference model, lcr scrambled mid-frame
        for (int n = 0; n < 30; n++) begin
            send_frame(8'($urandom), 8'($urandom), ($urandom % 4) == 0,
                       ($urandom % 5) != 0, 1'b1);
            check_frames("rnd");
        end
        chk("brk_total", brk_cnt, exp_brk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
